// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 7-segment scan driver with shadow data and per-digit blanking.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN additionally darkens leading zero digits above digit 0.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int PW = $clog2(REFRESH_DIV)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IW-1:0]           digit_idx
);
    logic [PW-1:0]           r_presc;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_data;
    logic [NUM_DIGITS-1:0]   r_blank;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    w_tick;
    logic [NUM_DIGITS-1:0]   w_dark;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic [3:0]              w_nib;
    logic                    w_off;
    logic [6:0]              w_dec;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic                    w_lz;
`endif

    assign w_tick    = r_presc == PW'(REFRESH_DIV - 1);
    assign w_sel     = NUM_DIGITS'(1) << r_idx;
    assign seg       = r_seg;
    assign an        = r_an;
    assign digit_idx = r_idx;

    // refresh prescaler and digit scan counter (wraps at NUM_DIGITS, not a power of two)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick)
                r_idx <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + IW'(1);
        end
    end

    // shadow registers capture the display word so the datapath may change freely
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_blank <= '0;
        end else if (load) begin
            r_data  <= data_in;
            r_blank <= blank_mask;
        end
    end

    // dark digits: explicit mask, plus leading zeros when enabled (digit 0 always lit)
    always_comb begin
        w_dark = r_blank;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        w_lz = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            w_lz      = w_lz && (r_data[4*k +: 4] == 4'h0);
            w_dark[k] = w_dark[k] | w_lz;
        end
`endif
    end

    // select the nibble and dark flag of the digit being scanned
    always_comb begin
        w_nib = 4'h0;
        w_off = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (r_idx == IW'(k)) begin
                w_nib = r_data[4*k +: 4];
                w_off = w_dark[k];
            end
    end

    // hex to segment decode, {a,b,c,d,e,f,g}
    always_comb begin
        w_dec = 7'b0000000;
        case (w_nib)
            4'h0: w_dec = 7'b1111110;
            4'h1: w_dec = 7'b0110000;
            4'h2: w_dec = 7'b1101101;
            4'h3: w_dec = 7'b1111001;
            4'h4: w_dec = 7'b0110011;
            4'h5: w_dec = 7'b1011011;
            4'h6: w_dec = 7'b1011111;
            4'h7: w_dec = 7'b1110000;
            4'h8: w_dec = 7'b1111111;
            4'h9: w_dec = 7'b1111011;
            4'hA: w_dec = 7'b1110111;
            4'hB: w_dec = 7'b0011111;
            4'hC: w_dec = 7'b1001110;
            4'hD: w_dec = 7'b0111101;
            4'hE: w_dec = 7'b1001111;
            4'hF: w_dec = 7'b1000111;
        endcase
    end

    // registered pin drive; a dark digit turns off both anode and segments
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= '0;
            r_an  <= '0;
        end else begin
            r_seg <= w_off ? 7'b0000000 : w_dec;
            r_an  <= w_off ? '0 : w_sel;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for seg7_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4.
module tb_seg7_scan_driver;
    typedef struct packed {
        int         cyc;
        logic [6:0] seg;
        logic [3:0] an;
        logic [1:0] idx;
        logic [7:0] tag;
    } exp_t;

    localparam logic [6:0] DEC [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    localparam logic [6:0] Z7 = 7'b1111110;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data_in = 16'h0;
    logic [3:0]  blank_mask = 4'h0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [1:0]  digit_idx;

    exp_t q[$];
    exp_t e;
    int   cyc;
    int   n_chk = 0;
    int   n_pass = 0;

    seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in),
        .blank_mask(blank_mask), .seg(seg), .an(an), .digit_idx(digit_idx)
    );

    always #5 clk = ~clk;

    // cycles elapsed since reset release
    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else cyc <= cyc + 1;

    // monitor: compares every expectation due at the current cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_chk++;
            if (e.cyc != cyc)
                $display("FAIL t%0d missed: due at cycle %0d, now %0d", e.tag, e.cyc, cyc);
            else if (seg !== e.seg || an !== e.an || digit_idx !== e.idx)
                $display("FAIL t%0d cyc %0d: got seg=%b an=%b idx=%0d, required seg=%b an=%b idx=%0d",
                         e.tag, cyc, seg, an, digit_idx, e.seg, e.an, e.idx);
            else
                n_pass++;
        end
    end

    function automatic logic [1:0] idx_at(int k);
        return 2'((k / 4) % 4);
    endfunction

    function automatic int dig_at(int k);
        return ((k - 1) / 4) % 4;
    endfunction

    task automatic expect_at(input int k, input logic [6:0] s, input logic [3:0] a, input logic [7:0] t);
        exp_t x;
        x.cyc = k; x.seg = s; x.an = a; x.idx = idx_at(k); x.tag = t;
        q.push_back(x);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_chk++;
            $display("FAIL drain timeout: %0d pending, required 0", q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] m);
        data_in = d; blank_mask = m; load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic scan(input logic [3:0][6:0] s, input logic [3:0] dark, input logic [7:0] t);
        int base;
        base = cyc;
        for (int k = base + 1; k <= base + 16; k++) begin
            int d;
            d = dig_at(k);
            expect_at(k, dark[d] ? 7'h0 : s[d], dark[d] ? 4'h0 : 4'(1 << d), t);
        end
        drain();
    endtask

    task automatic wait_mod(input int m);
        for (int i = 0; i < 32 && (cyc % 16) != m; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // 1: reset values, then idle scan of a zero shadow
        expect_at(0, 7'h0, 4'h0, 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        scan({4{Z7}}, 4'b0000, 1);
        // 2: back-to-back loads, last wins
        data_in = 16'h5555; load = 1'b1;
        @(posedge clk);
        #1 data_in = 16'h12AF;
        @(posedge clk);
        #1 load = 1'b0;
        scan({7'b0110000, 7'b1101101, 7'b1110111, 7'b1000111}, 4'b0000, 2);
        // 3: blank mask, load edge coincides with a tick
        wait_mod(3);
        do_load(16'h9999, 4'b0101);
        scan({4{7'b1111011}}, 4'b0101, 3);
        // 4: full decode sweep on digit 0
        for (int v = 0; v < 16; v++) begin
            int k;
            do_load({12'h0, 4'(v)}, 4'b0000);
            k = cyc + 1;
            while (dig_at(k) != 0) k++;
            expect_at(k, DEC[v], 4'b0001, 4);
            drain();
        end
        // 5: async reset mid-scan on digit 2; load during reset is ignored
        wait_mod(9);
        rst = 1'b1; load = 1'b1; data_in = 16'hFFFF; blank_mask = 4'hF;
        expect_at(0, 7'h0, 4'h0, 5);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; load = 1'b0;
        scan({4{Z7}}, 4'b0000, 5);
        // 6: leading zeros
        do_load(16'h0040, 4'b0000);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        scan({7'h0, 7'h0, 7'b0110011, Z7}, 4'b1100, 6);
        do_load(16'h0000, 4'b0000);
        scan({4{Z7}}, 4'b1110, 6);
`else
        scan({Z7, Z7, 7'b0110011, Z7}, 4'b0000, 6);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed driver for a multi-digit common-segment 7-segment display, parametrised in digit count and refresh rate.
- Latches a packed hex/BCD word into a shadow register on a load strobe.
- Scans the digits one at a time with a prescaled refresh counter.
- Decodes the selected nibble to segments, with per-digit blanking.
- Sits between the datapath (counters, timers) and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of display digits scanned (1..8).
- REFRESH_DIV, 50000, clock cycles each digit stays selected (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- load  input  1  one-cycle strobe; captures data_in and blank_mask into the shadow registers.
- data_in  input  4*NUM_DIGITS  packed nibbles; bits [3:0] are digit 0 (least significant).
- blank_mask  input  NUM_DIGITS  1 = force that digit dark.
- seg  output  7  segment drive, active-high, {a,b,c,d,e,f,g} on bits [6:0].
- an  output  NUM_DIGITS  digit enable, one-hot active-high, or all-zero when blanked.
- digit_idx  output  $clog2(NUM_DIGITS) (min 1)  index of the digit currently scanned.

Behaviour:
- Reset (async assert, sync release):
  - prescaler=0, digit_idx=0.
  - shadow data=0, shadow blank=0.
  - seg=7'b0000000, an=0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - tick is asserted in the cycle where prescaler==REFRESH_DIV-1.
- digit_idx advances by 1 on tick and wraps NUM_DIGITS-1 -> 0. NUM_DIGITS need not be a power of two.
- Shadow registers:
  - On load, shadow <= data_in / blank_mask at that clock edge.
  - load is ignored while rst=1.
  - load on consecutive cycles: the last value wins.
  - load and tick in the same cycle are independent; both take effect.
- seg and an are registered from the current digit_idx and current shadow contents.
  - They lag a digit_idx change by 1 cycle.
  - They lag a load edge by 1 cycle.
- an = one-hot(digit_idx) unless the selected digit is blanked; if blanked, an=0 and seg=0.
- Decode (seg, bits 6..0, a..g):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
- X/Z on data_in is never loaded unless load=1. If it is loaded, seg is don't-care, but an must still follow the scan.
- First output after reset release: one cycle later, seg=1111110, an=...0001.
- Reset mid-scan: all state returns to its reset values immediately. The scan restarts from digit 0 with a full REFRESH_DIV period.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: any digit k>0 whose nibble is 0 and whose higher digits k+1..NUM_DIGITS-1 are also all 0 is treated as blanked (an=0, seg=0), ORed with blank_mask. Digit 0 is never auto-blanked, so value 0 shows as a single "0".
- Not defined: only blank_mask blanks digits; all leading zeros display as "0".

Test Plan:
1. Reset and idle scan, NUM_DIGITS=4, REFRESH_DIV=4:
   - Hold rst 3 cycles, then release -> seg=0, an=0 during reset.
   - One cycle after release -> seg=1111110, an=0001.
   - digit_idx steps 0,1,2,3,0 every 4 cycles.
2. Load 16'h12AF, blank_mask=0 -> one cycle after load, the output matches the current digit_idx. Over one full scan:
   - an=0001, seg=1000111 (F)
   - an=0010, seg=1110111 (A)
   - an=0100, seg=1101101 (2)
   - an=1000, seg=0110000 (1)
3. Load 16'h9999, blank_mask=4'b0101 -> while digit_idx is 0 or 2: an=0, seg=0. While digit_idx is 1 or 3: an=0010/1000, seg=1111011.
4. Sweep data_in digit 0 through 0..15, loading each and waiting for digit 0 to be selected -> all 16 decode codes match the table.
5. Assert rst mid-period with digit_idx=2 -> immediately an=0, seg=0. After release, digit_idx=0 and the shadow holds 0.
6. With SEG7_LEADING_ZERO_BLANK_EN defined:
   - Load 16'h0040 -> digits 3 and 2 are dark; digit 1 shows 0110011; digit 0 shows 1111110.
   - Load 16'h0000 -> only digit 0 lit, showing 1111110.
